// File: rtl/cdc_isolate_pkg.sv
// Shared types for the consumer-side isolate/clear responder of the clearable CDC FIFO.
package cdc_isolate_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      ISOLATED,
      CLEARING
   } iso_state_e;

   // Both quiescent states report isolation to the reset controller.
   function automatic logic is_isolated(iso_state_e s);
      return (s == ISOLATED) || (s == CLEARING);
   endfunction

endpackage

// File: rtl/cdc_isolate_responder_if.sv
// Handshake bundle around the responder: isolate/clear requests, upstream and downstream streams.
interface cdc_isolate_responder_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_WIDTH = 8
);
   logic                 isolate_i;
   logic                 isolate_ack_o;
   logic                 clear_i;
   logic                 clear_ack_o;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [WIDTH-1:0]     in_data_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [WIDTH-1:0]     out_data_o;
   logic [CNT_WIDTH-1:0] drop_cnt_o;
   logic                 proto_err_o;

   modport slave (
      input  isolate_i, clear_i, in_valid_i, in_data_i, out_ready_i,
      output isolate_ack_o, clear_ack_o, in_ready_o, out_valid_o, out_data_o,
      output drop_cnt_o, proto_err_o
   );

   modport master (
      output isolate_i, clear_i, in_valid_i, in_data_i, out_ready_i,
      input  isolate_ack_o, clear_ack_o, in_ready_o, out_valid_o, out_data_o,
      input  drop_cnt_o, proto_err_o
   );
endinterface

// File: rtl/isolate_fifo_core.sv
// Circular buffer with wrap-at-DEPTH indices, occupancy count and a synchronous flush.
module isolate_fifo_core #(
   parameter int unsigned  WIDTH = 8,
   parameter type          T     = logic [WIDTH-1:0],
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  T              push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output T              head_o,
   output logic [CW-1:0] count_o
);

   T              mem_q [DEPTH];
   logic [IW-1:0] wr_q;
   logic [IW-1:0] rd_q;
   logic [CW-1:0] count_q;

   // DEPTH need not be a power of two, so wrap explicitly.
   function automatic logic [IW-1:0] wrap_inc(logic [IW-1:0] idx);
      return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wrap_inc(wr_q);
         if (pop_i)  rd_q <= wrap_inc(rd_q);
         unique case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy guards every read.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/cdc_isolate_responder.sv
// Consumer-side stream buffer that acknowledges isolation only with no open handshake,
// then flushes on clear and counts the dropped entries.
module cdc_isolate_responder
   import cdc_isolate_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter type         T         = logic [WIDTH-1:0],
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_WIDTH = 8
) (
   input logic                    clk_i,
   input logic                    rst_i,
   cdc_isolate_responder_if.slave bus
);

   localparam int unsigned   CW       = $clog2(DEPTH + 1);
   localparam int unsigned   SW       = ((CNT_WIDTH > CW) ? CNT_WIDTH : CW) + 1;
   localparam logic [SW-1:0] DROP_MAX = SW'({CNT_WIDTH{1'b1}});

   iso_state_e           st_q;
   iso_state_e           st_d;
   logic                 pending_q;
   logic                 iso_q;
   logic                 clr_q;
   logic                 iso_ack_q;
   logic                 clr_ack_q;
   logic                 proto_err_q;
   logic [CNT_WIDTH-1:0] drop_q;

   logic [CW-1:0]        count_c;
   T                     head_c;
   logic                 in_ready_c;
   logic                 out_valid_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 flush_c;
   logic                 err_c;
   logic [SW-1:0]        drop_sum_c;

   isolate_fifo_core #(
      .WIDTH (WIDTH),
      .T     (T),
      .DEPTH (DEPTH)
   ) u_core (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_c),
      .push_data_i (bus.in_data_i),
      .pop_i       (pop_c),
      .flush_i     (flush_c),
      .head_o      (head_c),
      .count_o     (count_c)
   );

   // A beat already presented stays up under isolate; nothing new is offered once isolate is seen.
   assign in_ready_c  = (st_q == RUN) && !bus.isolate_i && (count_c < CW'(DEPTH));
   assign out_valid_c = (count_c != '0) &&
                        (((st_q == RUN) && (!bus.isolate_i || pending_q)) || (st_q == DRAIN));
   assign push_c      = bus.in_valid_i && in_ready_c;
   assign pop_c       = out_valid_c && bus.out_ready_i;
   assign flush_c     = (st_q == ISOLATED) && (st_d == CLEARING);
   assign drop_sum_c  = SW'(drop_q) + SW'(count_c);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) st_q <= RUN;
      else       st_q <= st_d;
   end

   // Next state and ordering-violation detection; offending requests are ignored.
   always_comb begin
      st_d  = st_q;
      err_c = 1'b0;
      if (iso_q && !bus.isolate_i && bus.clear_i) err_c = 1'b1;
      unique case (st_q)
         RUN: begin
            if (bus.clear_i && !clr_q) err_c = 1'b1;
            if (bus.isolate_i) st_d = (pending_q && !bus.out_ready_i) ? DRAIN : ISOLATED;
         end
         DRAIN: begin
            if (bus.clear_i && !clr_q) err_c = 1'b1;
            if (bus.out_ready_i) st_d = ISOLATED;
         end
         ISOLATED: begin
            if (bus.isolate_i && bus.clear_i)        st_d = CLEARING;
            else if (!bus.isolate_i && !bus.clear_i) st_d = RUN;
         end
         CLEARING: begin
            if (!bus.clear_i) st_d = ISOLATED;
         end
         default: st_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q   <= 1'b0;
         iso_q       <= 1'b0;
         clr_q       <= 1'b0;
         iso_ack_q   <= 1'b0;
         clr_ack_q   <= 1'b0;
         proto_err_q <= 1'b0;
         drop_q      <= '0;
      end else begin
         pending_q   <= out_valid_c && !bus.out_ready_i;
         iso_q       <= bus.isolate_i;
         clr_q       <= bus.clear_i;
         iso_ack_q   <= is_isolated(st_d);
         clr_ack_q   <= (st_d == CLEARING);
         proto_err_q <= err_c;
         if (flush_c) drop_q <= (drop_sum_c > DROP_MAX) ? '1 : CNT_WIDTH'(drop_sum_c);
      end
   end

   assign bus.in_ready_o    = in_ready_c;
   assign bus.out_valid_o   = out_valid_c;
   assign bus.out_data_o    = head_c;
   assign bus.isolate_ack_o = iso_ack_q;
   assign bus.clear_ack_o   = clr_ack_q;
   assign bus.drop_cnt_o    = drop_q;
   assign bus.proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_cdc_isolate_responder.sv
// Scoreboard bench for cdc_isolate_responder: a default instance plus a 2-bit drop counter instance.
module tb_cdc_isolate_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdc_isolate_responder_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();
   cdc_isolate_responder_if #(.WIDTH(8), .CNT_WIDTH(2)) sbus ();

   cdc_isolate_responder #(.WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   cdc_isolate_responder #(.WIDTH(8), .DEPTH(4), .CNT_WIDTH(2)) u_sat (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sbus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_q [$];
   int unsigned exp_drop = 0;

   // One cycle of stimulus on the main instance; outputs settle 1 time unit after the falling edge.
   task automatic step(input logic iso, input logic clr, input logic iv,
                       input logic [7:0] d, input logic ordy);
      @(negedge clk);
      bus.isolate_i   = iso;
      bus.clear_i     = clr;
      bus.in_valid_i  = iv;
      bus.in_data_i   = d;
      bus.out_ready_i = ordy;
      #1;
   endtask

   task automatic sstep(input logic iso, input logic clr, input logic iv,
                        input logic [7:0] d, input logic ordy);
      @(negedge clk);
      sbus.isolate_i   = iso;
      sbus.clear_i     = clr;
      sbus.in_valid_i  = iv;
      sbus.in_data_i   = d;
      sbus.out_ready_i = ordy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (bus.isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_isolate_ack: got %b want 0", bus.isolate_ack_o); end
      n_cmp++; if (bus.clear_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_clear_ack: got %b want 0", bus.clear_ack_o); end
      n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
      n_cmp++; if (bus.proto_err_o !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err_o); end
      n_cmp++; if (bus.drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt_o); end
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [7:0] want;
      bit         empty;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
         n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.in_ready_o); end
         exp_q.push_back(8'hA0 + 8'(i));
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", bus.in_ready_o); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         empty = (exp_q.size() == 0);
         want  = empty ? 8'h00 : exp_q.pop_front();
         n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL drain_beat[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid_o, bus.out_data_o, want); end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", bus.out_valid_o); end
   endtask

   task automatic test_isolate_open();
      logic [7:0] want;
      bit         empty;
      step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL open_push0_ready: got %b want 1", bus.in_ready_o); end
      exp_q.push_back(8'h55);
      step(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL open_push1_ready: got %b want 1", bus.in_ready_o); end
      exp_q.push_back(8'h66);
      repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
         n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_q[0]) begin n_err++; $display("FAIL open_hold[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid_o, bus.out_data_o, exp_q[0]); end
         n_cmp++; if (bus.isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL open_early_ack[%0d]: got %b want 0", i, bus.isolate_ack_o); end
         n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL open_ready[%0d]: got %b want 0", i, bus.in_ready_o); end
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL open_accept: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.isolate_ack_o !== 1'b1) begin n_err++; $display("FAIL open_ack_rise: got %b want 1", bus.isolate_ack_o); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL open_no_new_beat[%0d]: got %b want 0", i, bus.out_valid_o); end
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.isolate_ack_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL open_release_cycle: got ack=%b v=%b want ack=1 v=0", bus.isolate_ack_o, bus.out_valid_o); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL open_ack_fall: got %b want 0", bus.isolate_ack_o); end
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL open_resume: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_isolate_no_clear();
      logic [7:0] want;
      bit         empty;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
         n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL keep_push_ready[%0d]: got %b want 1", i, bus.in_ready_o); end
         exp_q.push_back(8'hB0 + 8'(i));
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL keep_drain_beat: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.isolate_ack_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL keep_isolated: got ack=%b v=%b want ack=1 v=0", bus.isolate_ack_o, bus.out_valid_o); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         n_cmp++; if (bus.isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL keep_ack_low[%0d]: got %b want 0", i, bus.isolate_ack_o); end
         empty = (exp_q.size() == 0);
         want  = empty ? 8'h00 : exp_q.pop_front();
         n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL keep_deliver[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid_o, bus.out_data_o, want); end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL keep_empty: got %b want 0", bus.out_valid_o); end
   endtask

   task automatic test_clear();
      logic [7:0] want;
      bit         empty;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
         exp_q.push_back(8'hC0 + 8'(i));
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL clear_drain_beat: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.clear_ack_o !== 1'b0 || bus.drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL clear_before: got ack=%b drop=%0d want ack=0 drop=%0d", bus.clear_ack_o, bus.drop_cnt_o, exp_drop); end
      exp_drop = (exp_drop + exp_q.size() > 255) ? 255 : exp_drop + exp_q.size();
      exp_q.delete();
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.clear_ack_o !== 1'b1 || bus.drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL clear_ack_drop: got ack=%b drop=%0d want ack=1 drop=%0d", bus.clear_ack_o, bus.drop_cnt_o, exp_drop); end
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.proto_err_o !== 1'b1 || bus.clear_ack_o !== 1'b1) begin n_err++; $display("FAIL clear_iso_fall_err: got err=%b ack=%b want err=1 ack=1", bus.proto_err_o, bus.clear_ack_o); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.proto_err_o !== 1'b0) begin n_err++; $display("FAIL clear_err_pulse: got %b want 0", bus.proto_err_o); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.clear_ack_o !== 1'b0 || bus.isolate_ack_o !== 1'b1) begin n_err++; $display("FAIL clear_ack_fall: got cack=%b iack=%b want cack=0 iack=1", bus.clear_ack_o, bus.isolate_ack_o); end
      step(1'b0, 1'b0, 1'b1, 8'hD0, 1'b1);
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL clear_flushed: got v=%b rdy=%b iack=%b want v=0 rdy=1 iack=0", bus.out_valid_o, bus.in_ready_o, bus.isolate_ack_o); end
      exp_q.push_back(8'hD0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL clear_post_beat: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_saturation();
      int unsigned s_exp = 0;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) sstep(1'b0, 1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0);
         sstep(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
         sstep(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         sstep(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
         n_cmp++; if (sbus.isolate_ack_o !== 1'b1) begin n_err++; $display("FAIL sat_iso_ack[%0d]: got %b want 1", r, sbus.isolate_ack_o); end
         sstep(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
         s_exp = (s_exp + 3 > 3) ? 3 : s_exp + 3;
         sstep(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
         n_cmp++; if (sbus.clear_ack_o !== 1'b1 || sbus.drop_cnt_o !== 2'(s_exp)) begin n_err++; $display("FAIL sat_drop[%0d]: got ack=%b drop=%0d want ack=1 drop=%0d", r, sbus.clear_ack_o, sbus.drop_cnt_o, s_exp); end
         sstep(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
         sstep(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      end
   endtask

   task automatic test_proto_err();
      logic [7:0] want;
      bit         empty;
      int         pulses = 0;
      step(1'b0, 1'b0, 1'b1, 8'hF5, 1'b0);
      exp_q.push_back(8'hF5);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, (k < 3), 1'b0, 8'h00, 1'b0);
         if (bus.proto_err_o === 1'b1) pulses++;
         n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_q[0] || bus.clear_ack_o !== 1'b0) begin n_err++; $display("FAIL perr_no_flush[%0d]: got v=%b d=%h cack=%b want v=1 d=%h cack=0", k, bus.out_valid_o, bus.out_data_o, bus.clear_ack_o, exp_q[0]); end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL perr_pulse_count: got %0d want 1", pulses); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      empty = (exp_q.size() == 0);
      want  = empty ? 8'h00 : exp_q.pop_front();
      n_cmp++; if (empty || bus.out_valid_o !== 1'b1 || bus.out_data_o !== want) begin n_err++; $display("FAIL perr_beat: got v=%b d=%h want v=1 d=%h", bus.out_valid_o, bus.out_data_o, want); end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid_drain();
      step(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.isolate_ack_o !== 1'b0 || bus.drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL rst_pre_drain: got v=%b ack=%b drop=%0d want v=1 ack=0 drop=%0d", bus.out_valid_o, bus.isolate_ack_o, bus.drop_cnt_o, exp_drop); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.isolate_ack_o !== 1'b0 || bus.clear_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_async_flags: got v=%b iack=%b cack=%b want 0 0 0", bus.out_valid_o, bus.isolate_ack_o, bus.clear_ack_o); end
      n_cmp++; if (bus.proto_err_o !== 1'b0 || bus.drop_cnt_o !== 8'd0 || bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_async_rest: got err=%b drop=%0d rdy=%b want 0 0 0", bus.proto_err_o, bus.drop_cnt_o, bus.in_ready_o); end
      exp_q.delete();
      exp_drop = 0;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_cmp++; if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready_o, bus.out_valid_o); end
   endtask

   initial begin
      rst              = 1'b1;
      bus.isolate_i    = 1'b0;
      bus.clear_i      = 1'b0;
      bus.in_valid_i   = 1'b0;
      bus.in_data_i    = 8'h00;
      bus.out_ready_i  = 1'b0;
      sbus.isolate_i   = 1'b0;
      sbus.clear_i     = 1'b0;
      sbus.in_valid_i  = 1'b0;
      sbus.in_data_i   = 8'h00;
      sbus.out_ready_i = 1'b0;
      test_reset();
      test_fill_drain();
      test_isolate_open();
      test_isolate_no_clear();
      test_clear();
      test_saturation();
      test_proto_err();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
